// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register sitting directly behind the register file.
//   - Captures both RF read ports (with same-cycle write-back bypass) and the decoded
//     fields into the EX register.
//   - Detects load-use hazards against a load held in EX, inserts one bubble and
//     back-pressures decode; counts bubbles in a saturating counter.
//   - flush kills the EX contents and consumes the decode instruction.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   id_valid, id_ready              decode handshake
//   id_rs_addr, id_rt_addr          source registers (also drive the RF read ports)
//   id_uses_rt, id_rd_addr          rt-read flag, destination register
//   id_imm, id_ctrl                 immediate and decoded control bundle
//   rf_rs_data, rf_rt_data          RF read data
//   wb_en, wb_addr, wb_data         write-back port (bypassed around the RF)
//   flush                           kill EX contents
//   ex_ready, ex_valid              EX handshake
//   ex_rs/rt/rd_addr, ex_rs/rt_data captured addresses and operands
//   ex_imm, ex_ctrl                 captured immediate and control
//   stall_count                     load-use bubbles inserted, saturating
module id_ex_stage #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned CTRL_W       = 6,
  parameter int unsigned MEM_READ_BIT = 0,
  parameter bit          R0_ZERO      = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_rs_addr,
  output logic [ADDR_W-1:0] ex_rt_addr,
  output logic [ADDR_W-1:0] ex_rd_addr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  logic              adv;
  logic              hazard;
  logic              ex_rd_live;
  logic              id_rs_zero;
  logic              id_rt_zero;
  logic              ex_rs_zero;
  logic              ex_rt_zero;
  logic [DATA_W-1:0] byp_rs;
  logic [DATA_W-1:0] byp_rt;
  logic              ref_rs;
  logic              ref_rt;

  assign adv = ex_ready | ~ex_valid;

  // A load into r0 produces nothing a consumer could depend on.
  assign ex_rd_live = (ex_rd_addr != '0) | ~R0_ZERO;

  assign hazard = id_valid & ex_valid & ex_ctrl[MEM_READ_BIT] & ex_rd_live &
                  ((ex_rd_addr == id_rs_addr) | (id_uses_rt & (ex_rd_addr == id_rt_addr)));

  assign id_ready = flush | (adv & ~hazard);

  assign id_rs_zero = R0_ZERO && (id_rs_addr == '0);
  assign id_rt_zero = R0_ZERO && (id_rt_addr == '0);
  assign ex_rs_zero = R0_ZERO && (ex_rs_addr == '0);
  assign ex_rt_zero = R0_ZERO && (ex_rt_addr == '0);

  // Operand bypass: r0 constant beats write-back, write-back beats the RF.
  always_comb begin
    byp_rs = rf_rs_data;
    byp_rt = rf_rt_data;
    if (id_rs_zero) begin
      byp_rs = '0;
    end else if (wb_en && (wb_addr == id_rs_addr)) begin
      byp_rs = wb_data;
    end
    if (id_rt_zero) begin
      byp_rt = '0;
    end else if (wb_en && (wb_addr == id_rt_addr)) begin
      byp_rt = wb_data;
    end
  end

  // While EX is stalled the RF may still be written; refresh held operands so they
  // never go stale.
  assign ref_rs = ex_valid & wb_en & (wb_addr == ex_rs_addr) & ~ex_rs_zero;
  assign ref_rt = ex_valid & wb_en & (wb_addr == ex_rt_addr) & ~ex_rt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rs_addr  <= '0;
      ex_rt_addr  <= '0;
      ex_rd_addr  <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
      stall_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv && hazard) begin
      ex_valid <= 1'b0;
      if (stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
    end else if (adv) begin
      // Fields load even when id_valid=0; ex_valid marks them as dead.
      ex_valid   <= id_valid;
      ex_rs_addr <= id_rs_addr;
      ex_rt_addr <= id_rt_addr;
      ex_rd_addr <= id_rd_addr;
      ex_rs_data <= byp_rs;
      ex_rt_data <= byp_rt;
      ex_imm     <= id_imm;
      ex_ctrl    <= id_ctrl;
    end else begin
      if (ref_rs) begin
        ex_rs_data <= wb_data;
      end
      if (ref_rt) begin
        ex_rt_data <= wb_data;
      end
    end
  end

endmodule
